// File: rtl/game_state_ctrl.sv
// game_state_ctrl: frame-synchronous game sequencer.
// Tracks the game phase (INIT, START, PLAY, HIT, GAME_OVER) and the lives
// counter. Freezes and re-homes the player object, and selects which RGB
// layer is shown for each pixel.
// Optional build macro: HIT_BLINK_EN. When defined, the object blinks
// (8 frames on, 8 frames off) while in HIT.
module game_state_ctrl #(
    parameter int unsigned LIVES      = 3,    // 1..7
    parameter int unsigned HIT_FRAMES = 60,   // 1..255
    parameter int unsigned GO_FRAMES  = 120   // 1..255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pixel_tick,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       video_on,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       collision,
    input  logic       object_on,
    input  logic       overlay_on,
    output logic [2:0] state,
    output logic [2:0] lives,
    output logic       object_reset,
    output logic       freeze,
    output logic       frame_tick,
    output logic [1:0] rgb_sel
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_START = 3'd1,
        S_PLAY  = 3'd2,
        S_HIT   = 3'd3,
        S_GO    = 3'd4
    } state_t;

    localparam logic [2:0] LIVES_INIT = 3'(LIVES);
    localparam logic [7:0] HIT_LAST   = 8'(HIT_FRAMES - 1);
    localparam logic [7:0] GO_LAST    = 8'(GO_FRAMES);

    // rgb_sel encodings
    localparam logic [1:0] SEL_BLACK   = 2'd0;
    localparam logic [1:0] SEL_BG      = 2'd1;
    localparam logic [1:0] SEL_OBJECT  = 2'd2;
    localparam logic [1:0] SEL_OVERLAY = 2'd3;

    state_t     state_q, state_d;
    logic [2:0] lives_q, lives_d;
    logic       obj_rst_q, obj_rst_d;
    logic       armed_q, armed_d;
    logic       hit_pending_q, hit_pending_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    logic any_key;
    logic press;
    logic hit_now;
    logic state_chg;
    logic key_phase;
    logic obj_vis;

    // Frame boundary: first pixel of the first blanking line.
    assign frame_tick = pixel_tick && (x == 10'd0) && (y == 10'd480);

    assign any_key = up | down | left | right;
    // A press needs the keys to have been seen released since the last
    // accepted/discarded press or since entering a key-waiting phase.
    assign press   = armed_q & any_key;
    // A collision that lands on the frame_tick clk itself still counts.
    assign hit_now = hit_pending_q | collision;
    assign key_phase = (state_q == S_START) || (state_q == S_GO);

    // Next-state, lives and object re-home pulse.
    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        obj_rst_d = 1'b0;
        unique case (state_q)
            S_INIT: begin
                if (frame_tick) state_d = S_START;
            end
            S_START: begin
                // Only a press leaves START, so a coincident frame_tick
                // cannot pre-empt it.
                if (press) begin
                    state_d   = S_PLAY;
                    lives_d   = LIVES_INIT;
                    obj_rst_d = 1'b1;
                end
            end
            S_PLAY: begin
                if (frame_tick && hit_now) begin
                    lives_d = lives_q - 3'd1;
                    state_d = (lives_q <= 3'd1) ? S_GO : S_HIT;
                end
            end
            S_HIT: begin
                // Collisions are ignored here; recovery is purely timed.
                if (frame_tick && (frame_cnt_q == HIT_LAST)) state_d = S_PLAY;
            end
            S_GO: begin
                if (press && (frame_cnt_q == GO_LAST)) state_d = S_START;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    assign state_chg = (state_d != state_q);

    // Key arming: re-armed by any all-released clk, consumed by presses in
    // the key-waiting phases, and forced clear on entry to those phases so
    // a key held across the transition does not count.
    always_comb begin
        armed_d = armed_q;
        if (!any_key) begin
            armed_d = 1'b1;
        end else if (press && key_phase) begin
            armed_d = 1'b0;
        end
        if (state_chg && ((state_d == S_START) || (state_d == S_GO))) begin
            armed_d = 1'b0;
        end
    end

    // Collision latch: remembers a mid-frame collision until the next
    // frame boundary, where it is evaluated and dropped.
    always_comb begin
        hit_pending_d = hit_pending_q;
        if (frame_tick) begin
            hit_pending_d = 1'b0;
        end else if ((state_q == S_PLAY) && collision) begin
            hit_pending_d = 1'b1;
        end
    end

    // Frame counter: restarts on every phase change, counts frames in HIT
    // and GAME_OVER, and holds at GO_FRAMES in GAME_OVER.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (state_chg) begin
            frame_cnt_d = 8'd0;
        end else if (frame_tick && (state_q == S_HIT)) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else if (frame_tick && (state_q == S_GO) && (frame_cnt_q < GO_LAST)) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // State registers with asynchronous reset back to INIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_INIT;
            lives_q       <= 3'd0;
            obj_rst_q     <= 1'b0;
            armed_q       <= 1'b0;
            hit_pending_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            obj_rst_q     <= obj_rst_d;
            armed_q       <= armed_d;
            hit_pending_q <= hit_pending_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    // Object visibility per phase.
    always_comb begin
        obj_vis = 1'b0;
        unique case (state_q)
            S_PLAY: obj_vis = 1'b1;
`ifdef HIT_BLINK_EN
            S_HIT:  obj_vis = ~frame_cnt_q[3];
`else
            S_HIT:  obj_vis = 1'b1;
`endif
            S_GO:   obj_vis = 1'b1;
            default: obj_vis = 1'b0;
        endcase
    end

    // Layer select; zero latency from the pixel inputs.
    always_comb begin
        rgb_sel = SEL_BG;
        if (!video_on) begin
            rgb_sel = SEL_BLACK;
        end else if (overlay_on && key_phase) begin
            rgb_sel = SEL_OVERLAY;
        end else if (object_on && obj_vis) begin
            rgb_sel = SEL_OBJECT;
        end
    end

    assign state        = state_q;
    assign lives        = lives_q;
    assign object_reset = obj_rst_q;
    assign freeze       = (state_q != S_PLAY);

endmodule

// File: doc/game_state_ctrl.md
# game_state_ctrl

Frame-synchronous game sequencer between the VGA timing, keyboard, object and RGB-mux layers of the display top. Tracks game phase (init, start screen, play, hit recovery, game over) and a lives counter. Freezes and re-homes the player object. Drives the layer select that replaces the top-level's fixed black/object/background priority mux.

## Interface
Parameters:
- `LIVES`, 3: lives loaded on game start; legal 1..7.
- `HIT_FRAMES`, 60: frames spent in HIT before returning to PLAY; legal 1..255.
- `GO_FRAMES`, 120: frames GAME_OVER ignores keys; legal 1..255.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset is asynchronous and active-high.
- `pixel_tick` in 1: pixel enable from vga_sync.
- `x`, `y` in 10 each: current pixel location.
- `video_on` in 1: active display region.
- `up`, `down`, `left`, `right` in 1: key levels from key_detect.
- `collision` in 1: object collision level.
- `object_on` in 1: object pixel present.
- `overlay_on` in 1: start/game-over text pixel present.
- `state` out 3: INIT=0, START=1, PLAY=2, HIT=3, GAME_OVER=4.
- `lives` out 3: remaining lives.
- `object_reset` out 1: one-clk pulse; object returns to spawn.
- `freeze` out 1: object ignores motion; wired to game_over_object.
- `frame_tick` out 1: one-clk frame boundary pulse.
- `rgb_sel` out 2: 0 black, 1 background, 2 object, 3 overlay.

## Operation
- `frame_tick` = `pixel_tick` && x==0 && y==480, combinational.
- `any_key` = up|down|left|right. `armed` clears on entry to START or GAME_OVER and sets on any clk with `any_key`==0. A press is `armed` && `any_key`; accepting a press clears `armed`.
- `hit_pending` sets on `collision` in PLAY and clears on every `frame_tick`. Frame evaluation uses `hit_pending` | `collision`.
- `frame_cnt` is 8-bit, clears on every state change, and increments on `frame_tick` in HIT and GAME_OVER. In GAME_OVER it saturates at GO_FRAMES.

Transitions (registered, one clk):
- INIT → START on first `frame_tick`.
- START → PLAY on press. Loads `lives`=LIVES and pulses `object_reset`.
- PLAY, on `frame_tick` with a hit: lives−1. If the result is 0 → GAME_OVER, else → HIT.
- HIT → PLAY on `frame_tick` when `frame_cnt`==HIT_FRAMES−1. Collisions are ignored in HIT; no `object_reset`.
- GAME_OVER → START on press with `frame_cnt`==GO_FRAMES. Presses before that are discarded but clear `armed`.

Combinational outputs:
- `freeze` = (`state`≠PLAY).
- `rgb_sel` priority: !`video_on` → 0; `overlay_on` in START/GAME_OVER → 3; `object_on` && `obj_vis` → 2; else 1.
- `obj_vis` = 1 in PLAY, HIT and GAME_OVER, 0 in INIT and START; modified by HIT_BLINK_EN.

## Timing
- Reset values: `state`=0, `lives`=0, `object_reset`=0, `armed`=0, `hit_pending`=0, `frame_cnt`=0. `freeze`=1. `rgb_sel` follows its inputs, with `obj_vis`=0.
- `state` changes the clk after the triggering event. `object_reset` is high that same clk.
- `rgb_sel` has zero latency from pixel inputs; the top registers it on `pixel_tick`.
- Press and `frame_tick` in the same clk in START: the press wins.
- Reset asserted mid-frame or mid-HIT: immediate return to INIT. The first `frame_tick` after release advances to START.

## Configuration
- `HIT_BLINK_EN` defined: in HIT, `obj_vis` = ~`frame_cnt[3]`, so the object blinks with an 8-frame on/8-frame off period.
- `HIT_BLINK_EN` undefined: `obj_vis`=1 throughout HIT.

## Test plan
- Reset, run 2 frames, then tap `up` one clk → `state` 0→1 at frame 1 and 1→2 next clk; `lives`=3; `object_reset` high exactly 1 clk.
- Hold `left` across GAME_OVER→START, no release → `state` stays 1. Release, then press → `state`=2.
- In PLAY pulse `collision` 1 clk mid-frame → at `frame_tick`: `lives`=2, `state`=3. After 60 frames → `state`=2 with no `object_reset`. A collision during HIT leaves `lives`=2.
- Three separated hits → `state`=4, `lives`=0. A press at frame 50 is ignored; a press after 120 frames → `state`=1.
- `collision` and `frame_tick` in the same clk in PLAY → counted that frame (`lives` decremented).
- With HIT_BLINK_EN, `object_on`=1 in HIT → `rgb_sel`=2 for frames 0–7, 1 for frames 8–15. Without the macro, 2 throughout. With `video_on`=0 → always 0.
